// File: rtl/player_physics_if.sv
// Player-motion signal bundle: frame strobe, key/tile inputs and sprite outputs.
// master = driving side (keyboard/poller/renderer), slave = player_physics.
interface player_physics_if;
  logic        frame_clk;
  logic [15:0] keycode;
  logic [2:0]  poll_up, poll_down, poll_left, poll_right;
  logic [9:0]  DrawX, DrawY;
  logic [9:0]  Pos_X, Pos_Y;
  logic [1:0]  state;
  logic        facing_left;
  logic        is_player;

  modport master (
    output frame_clk, keycode, poll_up, poll_down, poll_left, poll_right, DrawX, DrawY,
    input  Pos_X, Pos_Y, state, facing_left, is_player
  );
  modport slave (
    input  frame_clk, keycode, poll_up, poll_down, poll_left, poll_right, DrawX, DrawY,
    output Pos_X, Pos_Y, state, facing_left, is_player
  );
endinterface

// File: rtl/player_physics.sv
// Fixed-point player mover, one update per frame_clk rise: walk, gravity, variable jump.
// Define PLAYER_MOMENTUM_EN for ramped horizontal velocity (X_ACCEL per frame).
module player_physics #(
  parameter int X_MIN         = 120,
  parameter int X_MAX         = 519,
  parameter int Y_MIN         = 40,
  parameter int Y_MAX         = 439,
  parameter int HALF_W        = 20,
  parameter int HALF_H        = 20,
  parameter int X_START       = 140,
  parameter int FRAC_BITS     = 4,
  parameter int GRAVITY       = 4,
  parameter int JUMP_VEL      = 64,
  parameter int VMAX_FALL     = 96,
  parameter int WALK_SPEED    = 16,
  parameter int X_ACCEL       = 2,
  parameter int JUMP_HOLD_MAX = 8
) (
  input logic Clk,
  input logic Reset,
  player_physics_if.slave io
);
  localparam int W   = 10 + FRAC_BITS;
  localparam int ONE = 1 << FRAC_BITS;

  typedef enum logic [1:0] {GROUNDED = 2'd0, RISING = 2'd1, FALLING = 2'd2} state_t;

  state_t                st, st_n;
  logic [W-1:0]          px, py, px_n, py_n;
  logic signed [W-1:0]   vx, vy, vx_n, vy_n;
  logic [7:0]            hold, hold_n;
  logic                  armed, armed_n, face, face_n;
  logic                  fc_d, fc_dd, upd;
  logic                  key_w, key_a, key_d, go_l, go_r;
  int                    xi, yi, lft, rgt, top, bot;
  int                    tgt, vxt, nx, vyt, ny;

  function automatic logic key_hit(input logic [15:0] kc, input logic [7:0] code);
    return (kc[7:0] == code) || (kc[15:8] == code);
  endfunction

  assign key_w = key_hit(io.keycode, 8'h1A);
  assign key_a = key_hit(io.keycode, 8'h04);
  assign key_d = key_hit(io.keycode, 8'h07);

  // Integer edges in signed int so tests near zero never wrap
  assign xi  = int'(px[W-1:FRAC_BITS]);
  assign yi  = int'(py[W-1:FRAC_BITS]);
  assign lft = xi - HALF_W;
  assign rgt = xi + HALF_W;
  assign top = yi - HALF_H;
  assign bot = yi + HALF_H;

  assign go_l = key_a && !key_d && io.poll_left  == 3'd0 && lft > X_MIN;
  assign go_r = key_d && !key_a && io.poll_right == 3'd0 && rgt < X_MAX;

  always_comb begin
    tgt = go_l ? -WALK_SPEED : (go_r ? WALK_SPEED : 0);
`ifdef PLAYER_MOMENTUM_EN
    vxt = 32'(vx);
    if ((vxt < 0 && (io.poll_left != 3'd0 || lft <= X_MIN)) ||
        (vxt > 0 && (io.poll_right != 3'd0 || rgt >= X_MAX)))
      vxt = 0;
    else if (vxt < tgt)
      vxt = (tgt - vxt > X_ACCEL) ? vxt + X_ACCEL : tgt;
    else if (vxt > tgt)
      vxt = (vxt - tgt > X_ACCEL) ? vxt - X_ACCEL : tgt;
`else
    vxt = tgt;
`endif
    nx = int'(px) + vxt;
    if (nx < (X_MIN + HALF_W) * ONE)
      nx = (X_MIN + HALF_W) * ONE;
    else if (nx >= (X_MAX - HALF_W + 1) * ONE)
      nx = (X_MAX - HALF_W) * ONE;
    face_n = go_l ? 1'b1 : (go_r ? 1'b0 : face);
  end

  assign vx_n = vxt[W-1:0];
  assign px_n = nx[W-1:0];

  always_comb begin
    st_n    = st;
    vyt     = 32'(vy);
    hold_n  = hold;
    armed_n = armed | ~key_w;
    case (st)
      GROUNDED: begin
        vyt = 0;
        if (key_w && armed && io.poll_up == 3'd0) begin
          st_n    = RISING;
          vyt     = -JUMP_VEL;
          hold_n  = 8'd1;
          armed_n = 1'b0;
        end else if (io.poll_down == 3'd0 && bot < Y_MAX) begin
          st_n = FALLING;
        end
      end
      RISING: begin
        if (key_w && hold < 8'(JUMP_HOLD_MAX)) hold_n = hold + 8'd1;
        else                                   vyt = vyt + GRAVITY;
        if (io.poll_up != 3'd0 || top <= Y_MIN) begin
          vyt  = 0;
          st_n = FALLING;
        end else if (vyt >= 0) begin
          st_n = FALLING;
        end
      end
      FALLING: vyt = (vyt + GRAVITY > VMAX_FALL) ? VMAX_FALL : vyt + GRAVITY;
      default: begin
        st_n = GROUNDED;
        vyt  = 0;
      end
    endcase
    ny = int'(py) + vyt;
    // Landing: a solid tile stops us in place, the floor snaps bottom to Y_MAX
    if (st == FALLING) begin
      if (io.poll_down != 3'd0) begin
        vyt  = 0;
        ny   = int'(py);
        st_n = GROUNDED;
      end else if ((ny >>> FRAC_BITS) + HALF_H >= Y_MAX) begin
        vyt  = 0;
        ny   = (Y_MAX - HALF_H) * ONE;
        st_n = GROUNDED;
      end
    end
    if (ny < (Y_MIN + HALF_H) * ONE) ny = (Y_MIN + HALF_H) * ONE;
  end

  assign vy_n = vyt[W-1:0];
  assign py_n = ny[W-1:0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fc_d  <= 1'b0;
      fc_dd <= 1'b0;
      upd   <= 1'b0;
      px    <= W'(X_START * ONE);
      py    <= W'((Y_MAX - HALF_H) * ONE);
      vx    <= '0;
      vy    <= '0;
      st    <= GROUNDED;
      hold  <= '0;
      armed <= 1'b1;
      face  <= 1'b0;
    end else begin
      fc_d  <= io.frame_clk;
      fc_dd <= fc_d;
      upd   <= fc_d & ~fc_dd;
      if (upd) begin
        px    <= px_n;
        py    <= py_n;
        vx    <= vx_n;
        vy    <= vy_n;
        st    <= st_n;
        hold  <= hold_n;
        armed <= armed_n;
        face  <= face_n;
      end
    end
  end

  assign io.Pos_X       = px[W-1:FRAC_BITS];
  assign io.Pos_Y       = py[W-1:FRAC_BITS];
  assign io.state       = st;
  assign io.facing_left = face;
  assign io.is_player   = (int'(io.DrawX) >= xi - HALF_W) && (int'(io.DrawX) < xi + HALF_W) &&
                          (int'(io.DrawY) >= yi - HALF_H) && (int'(io.DrawY) < yi + HALF_H);
endmodule
